mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
- Parameter LATENCY, default 2: cycles from memory issue to valid read data; legal range 1..15.
- Parameter MAX_STREAK, default 4: maximum consecutive data grants while an instruction request waits; legal range 1..15.
REQ-002 Ports SHALL be exactly the following, in this order (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- l1i_req  in  1  instruction read request; held until l1i_done
- l1i_address  in  32  instruction byte address
- l1i_done  out  1  one-cycle completion pulse to instruction cache
- l1i_rdata  out  32  instruction read data; valid while l1i_done
- l1d_req  in  1  data request; held until l1d_done
- l1d_write  in  1  1 = write, 0 = read; sampled with l1d_req
- l1d_address  in  32  data byte address
- l1d_wdata  in  32  data write value
- l1d_done  out  1  one-cycle completion pulse to data cache
- l1d_rdata  out  32  data read value; valid while l1d_done, 0 for writes
- stall_l1i  out  1  l1i_req and not l1i_done (combinational)
- stall_l1d  out  1  l1d_req and not l1d_done (combinational)
- mem_address  out  32  latched address of the granted request
- mem_wdata  out  32  latched write data
- mem_read  out  1  read strobe, high only in ISSUE
- mem_write  out  1  write strobe, high only in ISSUE
- mem_rdata  in  32  memory read data, valid LATENCY cycles after the ISSUE cycle

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-004 IDLE, if any request is pending: grant one requester; latch its address, write data and write flag; go to ISSUE. If no request is pending, remain in IDLE.
REQ-005 Arbitration SHALL be as follows:
- Only l1d_req high: grant data.
- Only l1i_req high: grant instruction.
- Both high: grant data, unless streak == MAX_STREAK, in which case grant instruction.
REQ-006 The streak counter (4 bits) SHALL be updated on each IDLE grant:
- Increment when data is granted while l1i_req is high.
- Clear when instruction is granted, or when data is granted with l1i_req low.
- Saturate at MAX_STREAK.
REQ-007 ISSUE SHALL last one cycle and assert mem_read (read) or mem_write (write), never both; the next state is WAIT with the wait counter set to LATENCY.
REQ-008 WAIT SHALL decrement the wait counter each cycle, capture mem_rdata at the end of the cycle in which the counter equals 1, and go to DONE at that edge.
REQ-009 DONE SHALL last one cycle:
- Pulse the granted requester's done output.
- Drive its rdata with the captured value (0 for writes).
- Go to IDLE.
REQ-010 Latency: request sampled in IDLE at cycle 0, ISSUE at cycle 1, done at cycle LATENCY+2; IDLE SHALL occupy at least one cycle between transactions.
REQ-011 mem_address and mem_wdata SHALL stay constant from ISSUE through DONE and pass through unmodified; no address translation is applied.
REQ-012 Request inputs SHALL be ignored outside IDLE; dropping a request mid-transaction SHALL NOT abort it, and the done pulse still fires.
REQ-013 The done and rdata outputs of the non-granted requester SHALL be 0 in all cycles.
REQ-014 The block SHALL hold at most one outstanding transaction; there is no queuing.

Reset
REQ-015 While reset is high at a clock edge, the next state SHALL be:
- FSM in IDLE; streak and wait counters at 0.
- Latched address, write data, write flag and captured data at 0.
- All outputs 0, except stall_l1i and stall_l1d, which follow their request inputs.
REQ-016 A reset asserted mid-transaction SHALL discard it with no done pulse; mem_read and mem_write SHALL be 0 from the cycle after the reset edge.

Verification
REQ-017 Single read: LATENCY=2; l1i_req=1 with address 0x40 at cycle 0, mem_rdata=0xDEADBEEF at cycle 3 -> mem_read=1 at cycle 1, l1i_done=1 and l1i_rdata=0xDEADBEEF at cycle 4.
REQ-018 Data write: l1d_req=1, l1d_write=1, address 0x84, wdata 0x12345678 -> mem_write=1 for one cycle with those values; l1d_done=1 with l1d_rdata=0 at cycle 4.
REQ-019 Contention: both requests held continuously, MAX_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; the instruction request is never starved.
REQ-020 Stall: while a request is pending, stall is 1; in the done cycle, stall is 0.
REQ-021 Reset at cycle 2 of a read -> no done pulse; IDLE with all outputs 0 next cycle; a fresh request then completes normally.
REQ-022 LATENCY=1 and LATENCY=15 sweeps -> done at cycle LATENCY+2 exactly; mem_read high for exactly one cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction and data caches share one memory port.
// One outstanding transaction, data-priority with a bounded streak for fairness.
module mem_arbiter #(
   parameter int LATENCY    = 2,
   parameter int MAX_STREAK = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        l1i_req,
   input  logic [31:0] l1i_address,
   output logic        l1i_done,
   output logic [31:0] l1i_rdata,
   input  logic        l1d_req,
   input  logic        l1d_write,
   input  logic [31:0] l1d_address,
   input  logic [31:0] l1d_wdata,
   output logic        l1d_done,
   output logic [31:0] l1d_rdata,
   output logic        stall_l1i,
   output logic        stall_l1d,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] LAT4 = 4'(LATENCY);
   localparam logic [3:0] MS4  = 4'(MAX_STREAK);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [3:0]  streak;
   logic [3:0]  wait_cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        wr_q;
   logic        gnt_d;
   logic        any_req;
   logic        pick_d;

   assign any_req = l1i_req | l1d_req;

   // Data wins unless the instruction side has waited out a full streak.
   assign pick_d = l1d_req & ~(l1i_req & (streak == MS4));

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            state_n = WAIT;
         end
         WAIT: begin
            if (wait_cnt == 4'd1) begin
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         streak   <= '0;
         wait_cnt <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         wr_q     <= 1'b0;
         gnt_d    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_d   <= pick_d;
                  wr_q    <= pick_d & l1d_write;
                  addr_q  <= pick_d ? l1d_address : l1i_address;
                  wdata_q <= pick_d ? l1d_wdata : 32'd0;
                  if (pick_d && l1i_req) begin
                     streak <= (streak < MS4) ? streak + 4'd1 : MS4;
                  end else begin
                     streak <= '0;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= LAT4;
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  rdata_q <= mem_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_read    = (state == ISSUE) & ~wr_q;
   assign mem_write   = (state == ISSUE) & wr_q;

   assign l1i_done  = (state == DONE) & ~gnt_d;
   assign l1d_done  = (state == DONE) & gnt_d;
   assign l1i_rdata = l1i_done ? rdata_q : 32'd0;
   assign l1d_rdata = (l1d_done & ~wr_q) ? rdata_q : 32'd0;

   assign stall_l1i = l1i_req & ~l1i_done;
   assign stall_l1d = l1d_req & ~l1d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model.
// Directed cases pin the model; two extra instances sweep LATENCY 1 and 15.
module tb_mem_arbiter;

   localparam int LAT = 2;
   localparam int MS  = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        l1i_req = 1'b0;
   logic [31:0] l1i_address = '0;
   logic        l1i_done;
   logic [31:0] l1i_rdata;
   logic        l1d_req = 1'b0;
   logic        l1d_write = 1'b0;
   logic [31:0] l1d_address = '0;
   logic [31:0] l1d_wdata = '0;
   logic        l1d_done;
   logic [31:0] l1d_rdata;
   logic        stall_l1i;
   logic        stall_l1d;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata = '0;

   // shared stimulus for the latency sweep instances
   logic        a_req = 1'b0;
   logic [31:0] a_addr = '0;
   logic [31:0] a_rdata = '0;
   logic        s1_done, s1_ddone, s1_si, s1_sd, s1_read, s1_write;
   logic [31:0] s1_rdata, s1_drdata, s1_addr, s1_wdata;
   logic        s15_done, s15_ddone, s15_si, s15_sd, s15_read, s15_write;
   logic [31:0] s15_rdata, s15_drdata, s15_addr, s15_wdata;

   int vectors = 0;
   int errors  = 0;

   always #5 clock = ~clock;

   mem_arbiter #(.LATENCY(LAT), .MAX_STREAK(MS)) u_dut (
      .clock(clock), .reset(reset),
      .l1i_req(l1i_req), .l1i_address(l1i_address),
      .l1i_done(l1i_done), .l1i_rdata(l1i_rdata),
      .l1d_req(l1d_req), .l1d_write(l1d_write),
      .l1d_address(l1d_address), .l1d_wdata(l1d_wdata),
      .l1d_done(l1d_done), .l1d_rdata(l1d_rdata),
      .stall_l1i(stall_l1i), .stall_l1d(stall_l1d),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.LATENCY(1), .MAX_STREAK(MS)) u_lat1 (
      .clock(clock), .reset(reset),
      .l1i_req(a_req), .l1i_address(a_addr),
      .l1i_done(s1_done), .l1i_rdata(s1_rdata),
      .l1d_req(1'b0), .l1d_write(1'b0),
      .l1d_address(32'd0), .l1d_wdata(32'd0),
      .l1d_done(s1_ddone), .l1d_rdata(s1_drdata),
      .stall_l1i(s1_si), .stall_l1d(s1_sd),
      .mem_address(s1_addr), .mem_wdata(s1_wdata),
      .mem_read(s1_read), .mem_write(s1_write),
      .mem_rdata(a_rdata)
   );

   mem_arbiter #(.LATENCY(15), .MAX_STREAK(MS)) u_lat15 (
      .clock(clock), .reset(reset),
      .l1i_req(a_req), .l1i_address(a_addr),
      .l1i_done(s15_done), .l1i_rdata(s15_rdata),
      .l1d_req(1'b0), .l1d_write(1'b0),
      .l1d_address(32'd0), .l1d_wdata(32'd0),
      .l1d_done(s15_ddone), .l1d_rdata(s15_drdata),
      .stall_l1i(s15_si), .stall_l1d(s15_sd),
      .mem_address(s15_addr), .mem_wdata(s15_wdata),
      .mem_read(s15_read), .mem_write(s15_write),
      .mem_rdata(a_rdata)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: a transaction is granted, then lives for LAT+2 cycles
   // counted by phase k (1 = strobe cycle, LAT+2 = completion cycle).
   bit          m_en = 1'b0;
   bit          m_busy = 1'b0;
   int          m_k = 0;
   bit          m_gd = 1'b0;
   bit          m_wr = 1'b0;
   int          m_streak = 0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_cap = '0;

   always @(negedge clock) begin
      bit e_str, e_fin, e_id, e_dd;
      e_str = m_busy && (m_k == 1);
      e_fin = m_busy && (m_k == LAT + 2);
      e_id  = e_fin && !m_gd;
      e_dd  = e_fin && m_gd;
      if (m_en) begin
         chk("mem_read", 32'(mem_read), 32'(e_str && !m_wr));
         chk("mem_write", 32'(mem_write), 32'(e_str && m_wr));
         chk("l1i_done", 32'(l1i_done), 32'(e_id));
         chk("l1d_done", 32'(l1d_done), 32'(e_dd));
         chk("l1i_rdata", l1i_rdata, e_id ? m_cap : 32'd0);
         chk("l1d_rdata", l1d_rdata,
             (e_dd && !m_wr) ? m_cap : 32'd0);
         chk("stall_l1i", 32'(stall_l1i), 32'(l1i_req && !e_id));
         chk("stall_l1d", 32'(stall_l1d), 32'(l1d_req && !e_dd));
         chk("mem_address", mem_address, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (reset) begin
         m_busy = 0; m_k = 0; m_gd = 0; m_wr = 0;
         m_streak = 0; m_addr = '0; m_wdata = '0; m_cap = '0;
      end else if (m_busy) begin
         if (m_k == LAT + 1) m_cap = mem_rdata;
         if (m_k == LAT + 2) m_busy = 0;
         else m_k++;
      end else if (l1i_req || l1d_req) begin
         m_gd = l1d_req && !(l1i_req && m_streak == MS);
         if (m_gd && l1i_req)
            m_streak = (m_streak + 1 > MS) ? MS : m_streak + 1;
         else
            m_streak = 0;
         m_addr  = m_gd ? l1d_address : l1i_address;
         m_wdata = m_gd ? l1d_wdata : 32'd0;
         m_wr    = m_gd && l1d_write;
         m_busy  = 1;
         m_k     = 1;
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      reset = 1'b1;
      l1i_req = 1'b0;
      l1d_req = 1'b0;
      a_req = 1'b0;
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      string order;
      int n, d1, d15, r1, r15, dn;
      logic [31:0] v1, v15;
      bit i_seen, d_seen;

      @(posedge clock);
      #1;
      m_en = 1'b1;
      @(negedge clock);
      chk("rst mem_read", 32'(mem_read), 32'd0);
      chk("rst mem_address", mem_address, 32'd0);
      chk("rst l1i_done", 32'(l1i_done), 32'd0);
      reset = 1'b0;

      // single instruction read
      next_cycle();
      l1i_req = 1'b1; l1i_address = 32'h40; mem_rdata = '0;
      @(negedge clock);
      chk("rd stall pending", 32'(stall_l1i), 32'd1);
      next_cycle();
      @(negedge clock);
      chk("rd mem_read c1", 32'(mem_read), 32'd1);
      chk("rd mem_address", mem_address, 32'h40);
      next_cycle();
      next_cycle();
      mem_rdata = 32'hDEADBEEF;
      next_cycle();
      mem_rdata = 32'd0;
      @(negedge clock);
      chk("rd l1i_done c4", 32'(l1i_done), 32'd1);
      chk("rd l1i_rdata c4", l1i_rdata, 32'hDEADBEEF);
      chk("rd stall done", 32'(stall_l1i), 32'd0);
      next_cycle();
      l1i_req = 1'b0;

      // data write
      do_reset();
      l1d_req = 1'b1; l1d_write = 1'b1;
      l1d_address = 32'h84; l1d_wdata = 32'h12345678;
      mem_rdata = 32'hFFFFFFFF;
      next_cycle();
      @(negedge clock);
      chk("wr mem_write c1", 32'(mem_write), 32'd1);
      chk("wr mem_read c1", 32'(mem_read), 32'd0);
      chk("wr mem_wdata", mem_wdata, 32'h12345678);
      chk("wr mem_address", mem_address, 32'h84);
      next_cycle();
      @(negedge clock);
      chk("wr mem_write c2", 32'(mem_write), 32'd0);
      next_cycle();
      next_cycle();
      @(negedge clock);
      chk("wr l1d_done c4", 32'(l1d_done), 32'd1);
      chk("wr l1d_rdata c4", l1d_rdata, 32'd0);
      next_cycle();
      l1d_req = 1'b0; l1d_write = 1'b0;

      // contention, both held
      do_reset();
      l1i_req = 1'b1; l1d_req = 1'b1;
      order = "";
      n = 0;
      while (order.len() < 10 && n < 200) begin
         @(negedge clock);
         if (l1d_done) order = {order, "D"};
         if (l1i_done) order = {order, "I"};
         next_cycle();
         n++;
      end
      vectors++;
      if (order != "DDDDIDDDDI") begin
         errors++;
         $display("FAIL grant order: got %s, expected DDDDIDDDDI", order);
      end
      l1i_req = 1'b0; l1d_req = 1'b0;

      // reset in the middle of a read
      do_reset();
      l1i_req = 1'b1; l1i_address = 32'h80;
      next_cycle();
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0; l1i_req = 1'b0;
      @(negedge clock);
      chk("mid-rst mem_read", 32'(mem_read), 32'd0);
      chk("mid-rst mem_address", mem_address, 32'd0);
      dn = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (l1i_done) dn++;
         next_cycle();
      end
      chk("mid-rst done count", 32'(dn), 32'd0);
      l1i_req = 1'b1; l1i_address = 32'h100; mem_rdata = 32'hCAFEF00D;
      n = 0;
      do begin
         @(negedge clock);
         i_seen = l1i_done;
         if (!i_seen) next_cycle();
         n++;
      end while (!i_seen && n < 50);
      chk("fresh done", 32'(i_seen), 32'd1);
      chk("fresh rdata", l1i_rdata, 32'hCAFEF00D);
      next_cycle();
      l1i_req = 1'b0;

      // latency sweep; request dropped after issue still completes
      do_reset();
      d1 = -1; d15 = -1; r1 = 0; r15 = 0; v1 = '0; v15 = '0;
      a_req = 1'b1; a_addr = 32'h200; a_rdata = 32'hA0000000;
      for (int c = 0; c < 24; c++) begin
         if (c > 0) begin
            next_cycle();
            a_rdata = 32'hA0000000 | 32'(c);
            if (c == 1) a_req = 1'b0;
         end
         @(negedge clock);
         if (s1_read) r1++;
         if (s15_read) r15++;
         if (s1_done && d1 < 0) begin d1 = c; v1 = s1_rdata; end
         if (s15_done && d15 < 0) begin d15 = c; v15 = s15_rdata; end
      end
      chk("lat1 done cycle", 32'(d1), 32'd3);
      chk("lat15 done cycle", 32'(d15), 32'd17);
      chk("lat1 read count", 32'(r1), 32'd1);
      chk("lat15 read count", 32'(r15), 32'd1);
      chk("lat1 rdata", v1, 32'hA0000002);
      chk("lat15 rdata", v15, 32'hA0000010);

      // randomized traffic against the model
      do_reset();
      i_seen = 0; d_seen = 0;
      for (int c = 0; c < 4000; c++) begin
         next_cycle();
         reset = ($urandom_range(0, 199) == 0);
         if (i_seen || (l1i_req && $urandom_range(0, 63) == 0))
            l1i_req = 1'b0;
         else if (!l1i_req && $urandom_range(0, 3) == 0)
            l1i_req = 1'b1;
         if (d_seen || (l1d_req && $urandom_range(0, 63) == 0))
            l1d_req = 1'b0;
         else if (!l1d_req && $urandom_range(0, 2) == 0)
            l1d_req = 1'b1;
         if ($urandom_range(0, 2) == 0) l1i_address = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            l1d_address = $urandom;
            l1d_wdata = $urandom;
            l1d_write = 1'($urandom_range(0, 1));
         end
         mem_rdata = $urandom;
         @(negedge clock);
         i_seen = l1i_done;
         d_seen = l1d_done;
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
